// File: rtl/async_fifo_pkg.sv
// Shared widths and types for the async FIFO read-side drain logic.
package async_fifo_pkg;

    localparam int DEFAULT_DWIDTH   = 8;
    localparam int DEFAULT_CNTWIDTH = 16;

    // Buffer occupancy 0..2; the value 3 is never legal.
    typedef logic [1:0]                  occ_t;
    typedef logic [DEFAULT_CNTWIDTH-1:0] cnt_t;

endpackage

// File: rtl/async_fifo_rd_buf.sv
// Two-entry ping-pong buffer that absorbs the FIFO's one-cycle read latency.
// Latency: a word written at an edge is visible on valid/data right after it.
// Backpressure: head word holds steady while valid && !ready; the caller must not overfill.
module async_fifo_rd_buf
    import async_fifo_pkg::*;
#(
    parameter int DWIDTH = DEFAULT_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              ready,
    output logic              valid,
    output logic [DWIDTH-1:0] data,
    output logic              accept,
    output occ_t              occ
);

    logic [DWIDTH-1:0] entry [2];
    logic              head;
    logic              tail;
    occ_t              occ_next;

    assign valid  = (occ != 2'd0);
    assign accept = valid && ready;
    assign data   = entry[head];

    // Tail is head + occ (mod 2): when the head is consumed on the same edge,
    // the new word lands in the other entry, which the toggled head then points at.
    assign tail     = head ^ occ[0];
    assign occ_next = occ + occ_t'(wr_en) - occ_t'(accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry[0] <= '0;
            entry[1] <= '0;
            head     <= 1'b0;
            occ      <= 2'd0;
        end else begin
            if (wr_en) begin
                entry[tail] <= wr_data;
            end
            if (accept) begin
                head <= ~head;
            end
            occ <= occ_next;
        end
    end

    a_occ_bound: assert property (@(posedge clk) disable iff (rst) occ != 2'd3);

endmodule

// File: rtl/async_fifo_rd_drain.sv
// Pops the async FIFO and presents the words as a valid/ready stream with a delivered-word count.
// Latency: pop sampled at edge N, word captured at N+1, m_valid right after N+1; 1 word/rclk sustained.
// Backpressure: pop is issued only while buffered + in-flight words after this edge's accept stay below 2.
module async_fifo_rd_drain
    import async_fifo_pkg::*;
#(
    parameter int DWIDTH   = DEFAULT_DWIDTH,
    parameter int CNTWIDTH = DEFAULT_CNTWIDTH
) (
    input  logic                rclk,
    input  logic                reset,
    input  logic                empty,
    output logic                pop,
    input  logic [DWIDTH-1:0]   rdata,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DWIDTH-1:0]   m_data,
    output logic [CNTWIDTH-1:0] count
);

    occ_t       occ;
    logic       accept;
    logic       inflight;
    logic [2:0] demand;

    async_fifo_rd_buf #(
        .DWIDTH (DWIDTH)
    ) u_buf (
        .clk     (rclk),
        .rst     (reset),
        .wr_en   (inflight),
        .wr_data (rdata),
        .ready   (m_ready),
        .valid   (m_valid),
        .data    (m_data),
        .accept  (accept),
        .occ     (occ)
    );

    // Committed slots after this edge; combinational in m_ready so a full
    // buffer that is being drained can still pop at full rate.
    assign demand = {1'b0, occ} + {2'b00, inflight} - {2'b00, accept};
    assign pop    = !reset && !empty && (demand < 3'd2);

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            count    <= '0;
        end else begin
            inflight <= pop;
            count    <= count + CNTWIDTH'(accept);
        end
    end

    a_no_pop_empty: assert property (@(posedge rclk) disable iff (reset) !(pop && empty));

endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// Bench: FIFO read-port model plus ordered scoreboard of every word written into the FIFO.
module tb_async_fifo_rd_drain;

    logic        rclk    = 1'b0;
    logic        reset   = 1'b1;
    logic        empty   = 1'b1;
    logic        m_ready = 1'b0;
    logic [7:0]  rdata   = 8'h00;
    logic        pop, pop4, m_valid, m_valid4;
    logic [7:0]  m_data, m_data4;
    logic [15:0] count;
    logic [3:0]  count4;

    int vectors   = 0;
    int errors    = 0;
    int model_cnt = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;

    always #5 rclk = ~rclk;

    async_fifo_rd_drain #(.DWIDTH(8), .CNTWIDTH(16)) dut (
        .rclk(rclk), .reset(reset), .empty(empty), .pop(pop), .rdata(rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .count(count)
    );

    async_fifo_rd_drain #(.DWIDTH(8), .CNTWIDTH(4)) dut4 (
        .rclk(rclk), .reset(reset), .empty(empty), .pop(pop4), .rdata(rdata),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .count(count4)
    );

    // FIFO read port: advances on the edge sampling pop, data valid the next cycle.
    always @(posedge rclk) begin
        if (pop) begin
            if (fifo_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_underflow: pop=1 with FIFO model empty, required pop=0");
            end else begin
                rdata <= fifo_q.pop_front();
            end
        end
        empty <= (fifo_q.size() == 0);
    end

    // Scoreboard: every transfer must be the next word written into the FIFO.
    always @(negedge rclk) begin
        #2;
        if (!reset) begin
            vectors++;
            if (pop4 !== pop || m_valid4 !== m_valid || m_data4 !== m_data) begin
                errors++;
                $display("FAIL twin_instance: pop/valid/data=%b/%b/%h, required %b/%b/%h",
                         pop4, m_valid4, m_data4, pop, m_valid, m_data);
            end
            if (m_valid && m_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_word: got %h, required no transfer", m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (m_data !== exp_w) begin
                        errors++;
                        $display("FAIL order: m_data=%h, required %h", m_data, exp_w);
                    end
                end
                model_cnt++;
            end
        end
    end

    task automatic push(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        empty = 1'b0;
    endtask

    task automatic hard_reset();
        @(negedge rclk);
        reset = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        model_cnt = 0;
        empty = 1'b1;
    endtask

    task automatic test_reset();
        m_ready = 1'b0;
        push(8'h3C);
        for (int i = 0; i < 4; i++) begin
            @(negedge rclk);
            #1;
            vectors++;
            if (pop !== 1'b0 || m_valid !== 1'b0 || count !== 16'd0 || m_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold: pop=%b m_valid=%b count=%0d m_data=%h, required 0/0/0/00",
                         pop, m_valid, count, m_data);
            end
        end
        @(negedge rclk);
        reset = 1'b0;
        #1;
        vectors++;
        if (pop !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_pop: pop=%b, required 1", pop);
        end
        m_ready = 1'b1;
        repeat (5) @(negedge rclk);
        #1;
        vectors++;
        if (count !== 16'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_first_word: count=%0d pending=%0d, required 1/0", count, exp_q.size());
        end
    endtask

    task automatic test_single();
        int start, first, nvalid, npop;
        start = model_cnt; first = -1; nvalid = 0; npop = 0;
        @(negedge rclk);
        m_ready = 1'b1;
        push(8'hA5);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge rclk);
            #1;
            if (pop) npop++;
            if (m_valid) begin
                nvalid++;
                if (first < 0) first = i;
                vectors++;
                if (m_data !== 8'hA5) begin
                    errors++;
                    $display("FAIL single_data: m_data=%h, required a5", m_data);
                end
            end
        end
        vectors++;
        if (npop != 1 || nvalid != 1 || first != 2) begin
            errors++;
            $display("FAIL single_timing: pops=%0d valid_cycles=%0d first_valid=%0d, required 1/1/2",
                     npop, nvalid, first);
        end
        vectors++;
        if (count !== 16'(start + 1)) begin
            errors++;
            $display("FAIL single_count: count=%0d, required %0d", count, start + 1);
        end
    endtask

    task automatic test_stream16();
        int start, first, last, nvalid;
        start = model_cnt; first = -1; last = -1; nvalid = 0;
        @(negedge rclk);
        m_ready = 1'b1;
        for (int w = 0; w < 16; w++) push(8'(w));
        for (int i = 0; i < 22; i++) begin
            if (i > 0) @(negedge rclk);
            #1;
            if (m_valid) begin
                nvalid++;
                last = i;
                if (first < 0) first = i;
            end
        end
        vectors++;
        if (first != 2 || last != 17 || nvalid != 16) begin
            errors++;
            $display("FAIL stream16_rate: first=%0d last=%0d valid_cycles=%0d, required 2/17/16",
                     first, last, nvalid);
        end
        vectors++;
        if (count !== 16'(start + 16)) begin
            errors++;
            $display("FAIL stream16_count: count=%0d, required %0d", count, start + 16);
        end
    endtask

    task automatic test_backpressure();
        int start, npop, bad;
        start = model_cnt; npop = 0; bad = 0;
        @(negedge rclk);
        m_ready = 1'b0;
        for (int w = 0; w < 8; w++) push(8'(w));
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge rclk);
            #1;
            if (pop) npop++;
            if (i >= 2 && (m_valid !== 1'b1 || m_data !== 8'h00)) bad++;
        end
        vectors++;
        if (npop != 2) begin
            errors++;
            $display("FAIL bp_pop_limit: pops=%0d, required 2", npop);
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d cycles with head not valid 00, required 0", bad);
        end
        @(negedge rclk);
        m_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge rclk);
            #1;
            if (pop) npop++;
        end
        vectors++;
        if (npop != 8 || count !== 16'(start + 8) || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: pops=%0d count=%0d pending=%0d, required 8/%0d/0",
                     npop, count, exp_q.size(), start + 8);
        end
    endtask

    task automatic test_random();
        int start, pushed, cyc;
        start = model_cnt; pushed = 0; cyc = 0;
        while ((pushed < 200 || exp_q.size() != 0) && cyc < 4000) begin
            @(negedge rclk);
            m_ready = 1'($urandom_range(0, 1));
            if (pushed < 200 && $urandom_range(0, 9) < 4) begin
                push(8'($urandom));
                pushed++;
            end
            cyc++;
        end
        @(negedge rclk);
        #1;
        vectors++;
        if (cyc >= 4000) begin
            errors++;
            $display("FAIL random_timeout: %0d words pending after %0d cycles, required 0", exp_q.size(), cyc);
        end
        vectors++;
        if (count !== 16'(start + 200)) begin
            errors++;
            $display("FAIL random_count: count=%0d, required %0d", count, start + 200);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge rclk);
        m_ready = 1'b0;
        for (int w = 0; w < 4; w++) push(8'hE0 + 8'(w));
        repeat (2) @(negedge rclk);
        reset = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        model_cnt = 0;
        empty = 1'b1;
        #1;
        vectors++;
        if (m_valid !== 1'b0 || count !== 16'd0 || count4 !== 4'd0 || pop !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: m_valid=%b count=%0d count4=%0d pop=%b, required 0/0/0/0",
                     m_valid, count, count4, pop);
        end
        repeat (2) @(negedge rclk);
        push(8'h77);
        push(8'h78);
        @(negedge rclk);
        reset = 1'b0;
        m_ready = 1'b1;
        #1;
        vectors++;
        if (pop !== 1'b1) begin
            errors++;
            $display("FAIL midop_resume: pop=%b, required 1", pop);
        end
        repeat (6) @(negedge rclk);
        #1;
        vectors++;
        if (count !== 16'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midop_after: count=%0d pending=%0d, required 2/0", count, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        hard_reset();
        @(negedge rclk);
        reset = 1'b0;
        m_ready = 1'b1;
        for (int w = 0; w < 17; w++) push(8'($urandom));
        repeat (25) @(negedge rclk);
        #1;
        vectors++;
        if (count4 !== 4'd1 || count !== 16'd17) begin
            errors++;
            $display("FAIL count_wrap: count4=%0d count=%0d, required 1/17", count4, count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream16();
        test_backpressure();
        test_random();
        test_reset_midop();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
